regfile_mp: RTL

Parametrised multi-port integer register file for the pipelined RISC-V core. It provides NRD combinational read ports and NWR write ports, with optional write-to-read bypass. A per-register pending scoreboard tracks hazards. After every reset, a hardware init sweep zeroes all registers and loads the stack pointer, so no per-register reset flops are needed.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_mp.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-core definitions: ABI register indices, register-file FSM states
// and the address-validity helper used by the register file and its scoreboard.
package riscv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned REG_AW   = 5;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 2;
    localparam int unsigned REG_A0   = 10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    // True for a writable/readable architectural register: not x0 and inside the array
    function automatic logic addr_ok(input logic [REG_AW-1:0] a, input int unsigned nreg);
        return (32'(a) != REG_ZERO) && (32'(a) < nreg);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for hazard tracking: set by issue, cleared by commit,
// looked up per read port with optional same-cycle write masking.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [NWR-1:0]        wr_vld,
    input  logic [NWR*REG_AW-1:0] wr_addr,
    input  logic                  sb_set_en,
    input  logic [REG_AW-1:0]     sb_set_addr,
    input  logic [NRD*REG_AW-1:0] rd_addr,
    output logic [NRD-1:0]        rd_pending
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nx;
    logic [REG_AW-1:0] wa [NWR];
    logic [REG_AW-1:0] ra [NRD];
    logic [NRD-1:0]    hit;
    logic              set_ok;

    // Commits clear first so that a same-cycle issue to the same register wins
    always_comb begin
        pending_nx = pending;
        set_ok     = run && sb_set_en && addr_ok(sb_set_addr, NREG);
        for (int unsigned p = 0; p < NWR; p++) begin
            wa[p] = wr_addr[REG_AW*p +: REG_AW];
            if (wr_vld[p]) begin
                pending_nx[wa[p][IW-1:0]] = 1'b0;
            end
        end
        if (set_ok) begin
            pending_nx[sb_set_addr[IW-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nx;
        end
    end

    // A forwarded value is already available, so the hazard is hidden when bypassing
    always_comb begin
        rd_pending = '0;
        hit        = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra[i] = rd_addr[REG_AW*i +: REG_AW];
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_vld[p] && (wa[p] == ra[i])) begin
                    hit[i] = 1'b1;
                end
            end
            rd_pending[i] = run && addr_ok(ra[i], NREG) && pending[ra[i][IW-1:0]]
                            && !(BYPASS && hit[i]);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write priority, optional write-to-read
// bypass, a pending scoreboard and a post-reset zeroing sweep that also loads sp.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned NREG       = 32,
    parameter int unsigned NRD        = 2,
    parameter int unsigned NWR        = 2,
    parameter bit          BYPASS     = 1'b1,
    parameter int unsigned SP_IDX     = REG_SP,
    parameter logic [31:0] INITIAL_SP = 32'h0000_00ff,
    parameter int unsigned DBG_IDX    = REG_A0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_busy,
    input  logic [NRD*REG_AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_pending,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*REG_AW-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic                  sb_set_en,
    input  logic [REG_AW-1:0]     sb_set_addr,
    output logic [XLEN-1:0]       dbg_data
);

    localparam int unsigned     IW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [XLEN-1:0] SP_VAL = XLEN'(INITIAL_SP);

    rf_state_e         state;
    rf_state_e         state_nx;
    logic [REG_AW-1:0] cnt;
    logic [REG_AW-1:0] cnt_nx;
    logic              init_busy_nx;
    logic              run;

    logic [XLEN-1:0]   regs   [NREG];
    logic [NREG-1:0]   reg_we;
    logic [XLEN-1:0]   reg_wd [NREG];

    logic [REG_AW-1:0] wa [NWR];
    logic [XLEN-1:0]   wd [NWR];
    logic [NWR-1:0]    wv;
    logic [REG_AW-1:0] ra [NRD];
    logic [XLEN-1:0]   rv [NRD];

    assign run = (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            init_busy <= init_busy_nx;
        end
    end

    // Sweep one register per clock; leave INIT after the last index
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        init_busy_nx = 1'b0;
        case (state)
            ST_INIT: begin
                cnt_nx       = cnt + REG_AW'(1);
                init_busy_nx = 1'b1;
                if (cnt == REG_AW'(NREG - 1)) begin
                    state_nx     = ST_RUN;
                    cnt_nx       = '0;
                    init_busy_nx = 1'b0;
                end
            end
            ST_RUN: begin
                state_nx = ST_RUN;
            end
            default: begin
                state_nx = ST_INIT;
            end
        endcase
    end

    always_comb begin
        for (int unsigned p = 0; p < NWR; p++) begin
            wa[p] = wr_addr[REG_AW*p +: REG_AW];
            wd[p] = wr_data[XLEN*p +: XLEN];
            wv[p] = run && wr_en[p] && addr_ok(wa[p], NREG);
        end
    end

    // Per-register write select; later ports override earlier ones
    always_comb begin
        reg_we = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            reg_wd[r] = '0;
            if (!run) begin
                if (cnt == REG_AW'(r)) begin
                    reg_we[r] = 1'b1;
                    reg_wd[r] = (r == SP_IDX) ? SP_VAL : '0;
                end
            end else begin
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (wv[p] && (wa[p] == REG_AW'(r))) begin
                        reg_we[r] = 1'b1;
                        reg_wd[r] = wd[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NREG; r++) begin
            if (reg_we[r]) begin
                regs[r] <= reg_wd[r];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra[i] = rd_addr[REG_AW*i +: REG_AW];
            rv[i] = '0;
            if (run && addr_ok(ra[i], NREG)) begin
                rv[i] = regs[ra[i][IW-1:0]];
                if (BYPASS) begin
                    for (int unsigned p = 0; p < NWR; p++) begin
                        if (wv[p] && (wa[p] == ra[i])) begin
                            rv[i] = wd[p];
                        end
                    end
                end
            end
            rd_data[XLEN*i +: XLEN] = rv[i];
        end
    end

    generate
        if (DBG_IDX < NREG) begin : g_dbg
            assign dbg_data = run ? regs[DBG_IDX] : '0;
        end else begin : g_nodbg
            assign dbg_data = '0;
        end
    endgenerate

    regfile_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .wr_vld      (wv),
        .wr_addr     (wr_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rd_addr     (rd_addr),
        .rd_pending  (rd_pending)
    );

endmodule
